// File: rtl/program_counter_pkg.sv
// Shared constants and next-PC selection type for the instruction-fetch program counter.
package program_counter_pkg;

  localparam int PC_W = 12;

  typedef enum logic [1:0] {
    PC_INC = 2'd0,
    PC_REL = 2'd1,
    PC_ABS = 2'd2
  } pc_sel_e;

  // Absolute wins over relative; both jump enables are meaningless without branch_en.
  function automatic pc_sel_e select_next(input logic branch_en,
                                          input logic reljump_en,
                                          input logic absjump_en);
    pc_sel_e sel;
    sel = PC_INC;
    if (branch_en && absjump_en) begin
      sel = PC_ABS;
    end else if (branch_en && reljump_en) begin
      sel = PC_REL;
    end
    return sel;
  endfunction

endpackage

// File: rtl/program_counter_if.sv
// Control-transfer bundle between branch/control logic (master) and the program counter (slave).
interface program_counter_if
  import program_counter_pkg::*;
#(
  parameter int D = PC_W
) ();

  logic         branch_en;
  logic         reljump_en;
  logic         absjump_en;
  logic [D-1:0] target;
  logic [D-1:0] prog_ctr;

  modport master (
    output branch_en,
    output reljump_en,
    output absjump_en,
    output target,
    input  prog_ctr
  );

  modport slave (
    input  branch_en,
    input  reljump_en,
    input  absjump_en,
    input  target,
    output prog_ctr
  );

endinterface

// File: rtl/program_counter.sv
// Instruction-fetch program counter: increments, jumps relative or jumps absolute each clock.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int D = PC_W
) (
  input  logic            clk,
  input  logic            reset,
  program_counter_if.slave pc
);

  logic [D-1:0] pc_q;
  logic [D-1:0] next_pc;
  pc_sel_e      sel;

  // Relative offset is added to the current PC (not PC+1); wrap is modulo 2^D.
  always_comb begin
    sel     = select_next(pc.branch_en, pc.reljump_en, pc.absjump_en);
    next_pc = pc_q + D'(1);
    case (sel)
      PC_ABS:  next_pc = pc.target;
      PC_REL:  next_pc = pc_q + pc.target;
      default: next_pc = pc_q + D'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= next_pc;
    end
  end

  assign pc.prog_ctr = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed plan plus randomized control against an integer model.
module tb_program_counter;

  localparam int D   = 12;
  localparam int MOD = 4096;

  logic clk;
  logic reset;

  program_counter_if #(.D(D)) bus ();

  program_counter #(.D(D)) dut (
    .clk   (clk),
    .reset (reset),
    .pc    (bus.slave)
  );

  int assertions;
  int failures;
  int model_pc;
  bit model_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: PC as a plain integer in [0, MOD), target interpreted as a signed offset for relative jumps.
  always @(posedge clk) begin
    int off;
    if (reset) begin
      model_pc    = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (bus.branch_en && bus.absjump_en) begin
        model_pc = int'(bus.target);
      end else if (bus.branch_en && bus.reljump_en) begin
        off = int'(bus.target);
        if (off >= MOD / 2) off = off - MOD;
        model_pc = (((model_pc + off) % MOD) + MOD) % MOD;
      end else begin
        model_pc = (model_pc + 1) % MOD;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      assertions++;
      if (bus.prog_ctr !== D'(model_pc)) begin
        failures++;
        $display("[TB] FAIL cycle_compare: prog_ctr=%0d model=%0d at %0t", bus.prog_ctr, model_pc, $time);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic b, input logic rel,
                               input logic abs, input logic [D-1:0] t);
    @(negedge clk);
    reset          = r;
    bus.branch_en  = b;
    bus.reljump_en = rel;
    bus.absjump_en = abs;
    bus.target     = t;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int expected);
    assertions++;
    if (bus.prog_ctr !== D'(expected)) begin
      failures++;
      $display("[TB] FAIL %s: prog_ctr=%0d expected=%0d", name, bus.prog_ctr, expected);
    end
    assertions++;
    if (model_pc != expected) begin
      failures++;
      $display("[TB] FAIL %s_model: model=%0d expected=%0d", name, model_pc, expected);
    end
  endtask

  initial begin
    assertions     = 0;
    failures       = 0;
    model_pc       = 0;
    model_valid    = 1'b0;
    reset          = 1'b1;
    bus.branch_en  = 1'b0;
    bus.reljump_en = 1'b0;
    bus.absjump_en = 1'b0;
    bus.target     = '0;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'd0);
    checkOutput("reset", 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'd4);
    checkOutput("rel_jump", 4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 12'd8);
    checkOutput("abs_jump", 8);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
    checkOutput("inc_1", 9);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
    checkOutput("inc_2", 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
    checkOutput("inc_3", 11);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 12'd20);
    checkOutput("abs_over_rel", 20);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 12'd100);
    checkOutput("gated_abs", 21);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'd300);
    checkOutput("branch_no_jump", 22);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 12'd4095);
    checkOutput("abs_max", 4095);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
    checkOutput("inc_wrap", 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 12'd10);
    checkOutput("abs_10", 10);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'hFFE);
    checkOutput("rel_neg2", 8);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'd0);
    checkOutput("rel_zero_hold", 8);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 12'd8);
    checkOutput("abs_self_hold", 8);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'hFF0);
    checkOutput("rel_wrap_down", 4088);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'd16);
    checkOutput("rel_wrap_up", 8);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 12'd55);
    checkOutput("reset_mid_jump", 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h800);
    checkOutput("rel_most_negative", 2048);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 40) == 0),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    D'($urandom));
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
